// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Serialises host (UART controller) and engine (CORDIC sqrt) accesses onto a
// single-port block RAM. Each transaction is one registered strobe followed by
// a one-cycle acknowledge; reads wait RD_LAT cycles for the RAM data.
// Optional macro ARB_ROUND_ROBIN_EN: when defined, ties alternate between the
// two ports; when undefined, the host always wins a tie (fixed priority).
module ram_access_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1    // legal range 1..3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_ack,
    output logic [DATA_W-1:0] e_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_t;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;

    logic              ram_en_reg, ram_en_next;
    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
    logic              h_ack_reg, h_ack_next;
    logic              e_ack_reg, e_ack_next;
    logic [DATA_W-1:0] h_rdata_reg, h_rdata_next;
    logic [DATA_W-1:0] e_rdata_reg, e_rdata_next;
    logic              gnt_reg, gnt_next;
    logic              busy_reg, busy_next;

    logic              any_req;
    logic              win_engine;

    assign any_req = h_req | e_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_reg;

    // Tie goes to the port that did not win the previous grant.
    always_comb win_engine = e_req & (~h_req | ~last_reg);

    // Remember the most recent winner; starts as engine so the host wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset)
            last_reg <= 1'b1;
        else if (state_reg == ST_IDLE && any_req)
            last_reg <= win_engine;
    end
`else
    // Fixed priority: the engine only wins when the host is not requesting.
    always_comb win_engine = e_req & ~h_req;
`endif

    // State and read-latency counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; a write skips WAIT, a read spends RD_LAT cycles there.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE:  if (any_req) state_next = ST_ISSUE;
            ST_ISSUE: begin
                if (ram_we_reg) begin
                    state_next = ST_ACK;
                end else begin
                    state_next = ST_WAIT;
                    cnt_next   = LAT_INIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 2'd1;
                if (cnt_reg == 2'd1) state_next = ST_ACK;
            end
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs, so nothing on the ports is combinational.
    always_comb begin
        ram_en_next    = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        h_ack_next     = 1'b0;
        e_ack_next     = 1'b0;
        h_rdata_next   = h_rdata_reg;
        e_rdata_next   = e_rdata_reg;
        gnt_next       = gnt_reg;
        busy_next      = (state_next != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    ram_en_next = 1'b1;
                    gnt_next    = win_engine;
                    if (win_engine) begin
                        ram_we_next    = e_we;
                        ram_addr_next  = e_addr;
                        ram_wdata_next = e_wdata;
                    end else begin
                        ram_we_next    = h_we;
                        ram_addr_next  = h_addr;
                        ram_wdata_next = h_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (ram_we_reg) begin
                    h_ack_next = ~gnt_reg;
                    e_ack_next = gnt_reg;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 2'd1) begin
                    h_ack_next = ~gnt_reg;
                    e_ack_next = gnt_reg;
                    if (gnt_reg) e_rdata_next = ram_rdata;
                    else         h_rdata_next = ram_rdata;
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset clears everything, abandoning any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            h_ack_reg     <= 1'b0;
            e_ack_reg     <= 1'b0;
            h_rdata_reg   <= '0;
            e_rdata_reg   <= '0;
            gnt_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            ram_en_reg    <= ram_en_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            h_ack_reg     <= h_ack_next;
            e_ack_reg     <= e_ack_next;
            h_rdata_reg   <= h_rdata_next;
            e_rdata_reg   <= e_rdata_next;
            gnt_reg       <= gnt_next;
            busy_reg      <= busy_next;
        end
    end

    assign ram_en    = ram_en_reg;
    assign ram_we    = ram_we_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign h_ack     = h_ack_reg;
    assign e_ack     = e_ack_reg;
    assign h_rdata   = h_rdata_reg;
    assign e_rdata   = e_rdata_reg;
    assign gnt_id    = gnt_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Testbench for ram_access_arbiter: transaction-timeline model checked every
// cycle, plus directed transactions with hand-computed expectations.
// Honours ARB_ROUND_ROBIN_EN for the tie-break expectations.
module tb_ram_access_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        h_req = 1'b0, h_we = 1'b0;
    logic [15:0] h_addr = '0, h_wdata = '0;
    logic        e_req = 1'b0, e_we = 1'b0;
    logic [15:0] e_addr = '0, e_wdata = '0;
    logic        h_ack, e_ack, ram_en, ram_we, busy, gnt_id;
    logic [15:0] h_rdata, e_rdata, ram_addr, ram_wdata, ram_rdata;

    ram_access_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ack(h_ack), .h_rdata(h_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_ack(e_ack), .e_rdata(e_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_val(input int a);
        return (a == 'h12) ? 16'h00B5 : 16'(16'h1000 + a);
    endfunction

    // RAM with LAT-cycle read pipeline
    logic [15:0] ram_mem [0:255];
    logic [15:0] rd_pipe [0:LAT-1];
    logic        ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
            ram_ready <= 1'b1;
        end else begin
            if (ram_en && ram_we)  ram_mem[ram_addr[7:0]] <= ram_wdata;
            if (ram_en && !ram_we) rd_pipe[0] <= ram_mem[ram_addr[7:0]];
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign ram_rdata = rd_pipe[LAT-1];

    // Model: each grant fixes a timeline (strobe cycle, ack cycle, next idle sample)
    logic [15:0] mdl_mem [0:255];
    int   cyc = 0, start_c = 0, ack_c = 0, free_edge = 0;
    bit   started = 0, active = 0;
    logic m_we = 0, m_gnt = 0, m_last = 1, pe;
    logic [15:0] m_addr = 0, m_wdata = 0, m_hr = 0, m_er = 0;

    initial begin
        for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                started = 1; active = 0; free_edge = cyc + 1;
                m_gnt = 0; m_we = 0; m_addr = 0; m_wdata = 0;
                m_hr = 0; m_er = 0; m_last = 1;
            end else if (started) begin
                if (active && cyc == ack_c && !m_we) begin
                    if (m_gnt) m_er = mdl_mem[m_addr[7:0]];
                    else       m_hr = mdl_mem[m_addr[7:0]];
                end
                if (cyc >= free_edge && (h_req || e_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pe = (h_req && e_req) ? !m_last : e_req;
`else
                    pe = e_req && !h_req;
`endif
                    m_last  = pe;
                    m_gnt   = pe;
                    m_we    = pe ? e_we : h_we;
                    m_addr  = pe ? e_addr : h_addr;
                    m_wdata = pe ? e_wdata : h_wdata;
                    active  = 1;
                    start_c = cyc;
                    ack_c   = cyc + (m_we ? 1 : 1 + LAT);
                    free_edge = ack_c + 2;
                    if (m_we) mdl_mem[m_addr[7:0]] = m_wdata;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("busy",      busy,      active && cyc >= start_c && cyc <= ack_c);
            chk("ram_en",    ram_en,    active && cyc == start_c);
            chk("ram_we",    ram_we,    active && cyc == start_c && m_we);
            chk("ram_addr",  ram_addr,  m_addr);
            chk("ram_wdata", ram_wdata, m_wdata);
            chk("h_ack",     h_ack,     active && cyc == ack_c && !m_gnt);
            chk("e_ack",     e_ack,     active && cyc == ack_c && m_gnt);
            chk("h_rdata",   h_rdata,   m_hr);
            chk("e_rdata",   e_rdata,   m_er);
            chk("gnt_id",    gnt_id,    m_gnt);
        end
    end

    // One transaction on one port, from an idle arbiter
    task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, output logic [15:0] rd,
                       output int lat, output logic gnt, output int en_cnt,
                       output logic [15:0] iss_addr, output logic [15:0] iss_data,
                       output logic iss_we, output int other_acks);
        bit seen;
        int n;
        if (port == 0) begin h_we = we; h_addr = addr; h_wdata = wdata; h_req = 1; end
        else           begin e_we = we; e_addr = addr; e_wdata = wdata; e_req = 1; end
        n = 0; seen = 0; en_cnt = 0; other_acks = 0;
        iss_addr = 'x; iss_data = 'x; iss_we = 1'bx;
        while (!seen && n < 50) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (ram_en) begin
                en_cnt++; iss_addr = ram_addr; iss_data = ram_wdata; iss_we = ram_we;
            end
            if (port == 0 ? e_ack : h_ack) other_acks++;
            if (port == 0 ? h_ack : e_ack) seen = 1;
        end
        chk(port ? "e_ack_timeout" : "h_ack_timeout", 32'(seen), 1);
        rd  = port ? e_rdata : h_rdata;
        gnt = gnt_id;
        lat = n;
        h_req = 0; e_req = 0;
        @(negedge clk);
        $display("txn port=%0d we=%0d addr=%h wdata=%h rdata=%h lat=%0d", port, we, addr, wdata, rd, lat);
    endtask

    logic [15:0] rd, ia, id;
    logic        g, iw;
    int          lat, enc, oth;

    initial begin
        // Reset with both requests high
        reset = 0; h_req = 1; e_req = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy",   busy,   0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_h_ack",  h_ack,  0);
        chk("rst_e_ack",  e_ack,  0);
        chk("rst_gnt",    gnt_id, 0);
        h_req = 0; e_req = 0; reset = 1;
        @(negedge clk);

        // Engine read of 0012 returns 00B5
        txn(1, 0, 16'h0012, 16'h0000, rd, lat, g, enc, ia, id, iw, oth);
        chk("e_rd_data", rd, 16'h00B5);
        chk("e_rd_lat",  lat, 4);
        chk("e_rd_gnt",  g, 1);
        chk("e_rd_en",   enc, 1);
        chk("e_rd_we",   iw, 0);
        chk("e_rd_hack", oth, 0);

        // Tie: both ports hold write requests for four transactions
        begin
            logic [3:0] ord;
            int got, guard, ecnt;
            ord = '0; got = 0; guard = 0; ecnt = 0;
            h_we = 1; h_addr = 16'h0020; h_wdata = 16'h1111;
            e_we = 1; e_addr = 16'h0030; e_wdata = 16'h2222;
            h_req = 1; e_req = 1;
            while (got < 4 && guard < 100) begin
                @(negedge clk); guard++;
                if (h_ack) begin ord[got] = 1'b0; got++; $display("tie ack host"); end
                else if (e_ack) begin ord[got] = 1'b1; got++; ecnt++; $display("tie ack engine"); end
            end
            h_req = 0; e_req = 0;
            chk("tie_count", got, 4);
`ifdef ARB_ROUND_ROBIN_EN
            chk("tie_order", ord, 4'b1010);
            chk("tie_e_acks", ecnt, 2);
`else
            chk("tie_order", ord, 4'b0000);
            chk("tie_e_acks", ecnt, 0);
`endif
            repeat (2) @(negedge clk);
        end

        // Host write BEEF to 0012
        txn(0, 1, 16'h0012, 16'hBEEF, rd, lat, g, enc, ia, id, iw, oth);
        chk("h_wr_lat",  lat, 2);
        chk("h_wr_en",   enc, 1);
        chk("h_wr_addr", ia, 16'h0012);
        chk("h_wr_data", id, 16'hBEEF);
        chk("h_wr_we",   iw, 1);
        chk("h_wr_eack", oth, 0);
        chk("h_wr_gnt",  g, 0);

        // Host read-back
        txn(0, 0, 16'h0012, 16'h0000, rd, lat, g, enc, ia, id, iw, oth);
        chk("h_rd_data", rd, 16'hBEEF);
        chk("h_rd_lat",  lat, 4);

        // Reset during WAIT of a host read
        begin
            int acks;
            acks = 0;
            h_we = 0; h_addr = 16'h0012; h_req = 1;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            reset = 0; h_req = 0;
            @(negedge clk);
            chk("mid_rst_busy",  busy, 0);
            chk("mid_rst_rdata", h_rdata, 0);
            reset = 1;
            repeat (5) begin
                @(negedge clk);
                if (h_ack || e_ack) acks++;
            end
            chk("mid_rst_noack", acks, 0);
            $display("mid-read reset: acks after reset=%0d", acks);
        end

        // Fresh host read completes normally
        txn(0, 0, 16'h0012, 16'h0000, rd, lat, g, enc, ia, id, iw, oth);
        chk("post_rst_data", rd, 16'hBEEF);
        chk("post_rst_lat",  lat, 4);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
